int_vector_ctrl: RTL and testbench

Parametrised interrupt controller for the writeback stage, generalising the fixed eight-entry vector table and single saved PC. It holds a per-channel vector table, enable mask and edge-latched pending bits, and selects the winning channel by fixed priority. It keeps a return stack so higher-priority interrupts can preempt active handlers. The WB stage supplies the resume PC and retire strobes, and takes the vector from this block as its next PC.

---
 rtl/int_vector_ctrl.sv | 165 ++++++++++++++++
 tb/tb_int_vector_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/int_vector_ctrl.sv
// Fixed-priority interrupt controller with vector table, edge-latched pending bits and return stack.
// Define INT_NEST_EN to allow preemption up to DEPTH levels; otherwise a single level is kept.
module int_vector_ctrl #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [CHANNELS-1:0]         int_req_i,
  input  logic                        step_i,
  input  logic                        reti_i,
  input  logic [PC_W-1:0]             pc_i,
  input  logic                        cfg_we_i,
  input  logic [1:0]                  cfg_sel_i,
  input  logic [$clog2(CHANNELS)-1:0] cfg_ch_i,
  input  logic [PC_W-1:0]             cfg_data_i,
  output logic                        take_o,
  output logic [PC_W-1:0]             vector_o,
  output logic                        ret_valid_o,
  output logic [PC_W-1:0]             ret_pc_o,
  output logic                        active_o,
  output logic [$clog2(CHANNELS)-1:0] active_ch_o,
  output logic [CHANNELS-1:0]         pending_o,
  output logic [CHANNELS-1:0]         enable_o,
  output logic                        err_o
);

  localparam int unsigned CH_W = $clog2(CHANNELS);
`ifdef INT_NEST_EN
  localparam int unsigned STK = DEPTH;
`else
  localparam int unsigned STK = 1;
`endif
  localparam int unsigned DW = $clog2(STK + 1);

  logic [CHANNELS-1:0] req_q, pend_q, pend_d, en_q, en_d, elig;
  logic [PC_W-1:0]     vec_q [CHANNELS];
  logic [PC_W-1:0]     vec_d [CHANNELS];
  logic [PC_W-1:0]     stk_pc_q [STK];
  logic [PC_W-1:0]     stk_pc_d [STK];
  logic [CH_W-1:0]     stk_ch_q [STK];
  logic [CH_W-1:0]     stk_ch_d [STK];
  logic [DW-1:0]       depth_q, depth_d;
  logic [CH_W-1:0]     act_ch_q, act_ch_d, win;
  logic                win_vld, active, cfg_hit, do_ret, do_entry;
  logic                take_q, take_d, retv_q, retv_d, err_q, err_d;
  logic [PC_W-1:0]     vector_q, vector_d, ret_pc_q, ret_pc_d;

  assign active   = (depth_q != '0);
  assign cfg_hit  = cfg_we_i && (32'(cfg_ch_i) < CHANNELS);
  assign do_ret   = reti_i && active;
  // Without nesting STK is 1, so the depth check alone blocks entry while active.
  assign do_entry = step_i && !reti_i && win_vld && (depth_q < DW'(STK));

  always_comb begin
    elig    = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      elig[i] = pend_q[i] & en_q[i] & (!active || (CH_W'(i) < act_ch_q));
    end
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win     = CH_W'(i);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d   = pend_q;
    en_d     = en_q;
    vec_d    = vec_q;
    err_d    = err_q;
    stk_pc_d = stk_pc_q;
    stk_ch_d = stk_ch_q;
    depth_d  = depth_q;
    act_ch_d = act_ch_q;
    take_d   = do_entry;
    retv_d   = do_ret;
    vector_d = vector_q;
    ret_pc_d = ret_pc_q;

    if (cfg_hit) begin
      unique case (cfg_sel_i)
        2'b00:   vec_d[cfg_ch_i] = cfg_data_i;
        2'b01:   en_d[cfg_ch_i] = cfg_data_i[0];
        2'b10:   pend_d[cfg_ch_i] = 1'b0;
        default: ;
      endcase
    end
    if (cfg_we_i && cfg_sel_i == 2'b11) err_d = 1'b0;
    if (reti_i && !active) err_d = 1'b1;

    if (do_ret) begin
      for (int i = 0; i < int'(STK); i++) begin
        if (depth_q == DW'(i + 1)) begin
          ret_pc_d = stk_pc_q[i];
          act_ch_d = stk_ch_q[i];
        end
      end
      depth_d = depth_q - DW'(1);
    end else if (do_entry) begin
      for (int i = 0; i < int'(STK); i++) begin
        if (depth_q == DW'(i)) begin
          stk_pc_d[i] = pc_i;
          stk_ch_d[i] = act_ch_q;
        end
      end
      depth_d     = depth_q + DW'(1);
      act_ch_d    = win;
      pend_d[win] = 1'b0;
      vector_d    = vec_q[win];
    end

    // A fresh edge overrides any clear in the same cycle.
    pend_d = pend_d | (int_req_i & ~req_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q    <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      depth_q  <= '0;
      act_ch_q <= '0;
      take_q   <= 1'b0;
      retv_q   <= 1'b0;
      err_q    <= 1'b0;
      vector_q <= '0;
      ret_pc_q <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) vec_q[i] <= '0;
      for (int i = 0; i < int'(STK); i++) begin
        stk_pc_q[i] <= '0;
        stk_ch_q[i] <= '0;
      end
    end else begin
      req_q    <= int_req_i;
      pend_q   <= pend_d;
      en_q     <= en_d;
      vec_q    <= vec_d;
      depth_q  <= depth_d;
      act_ch_q <= act_ch_d;
      stk_pc_q <= stk_pc_d;
      stk_ch_q <= stk_ch_d;
      take_q   <= take_d;
      retv_q   <= retv_d;
      err_q    <= err_d;
      vector_q <= vector_d;
      ret_pc_q <= ret_pc_d;
    end
  end

  assign take_o      = take_q;
  assign vector_o    = vector_q;
  assign ret_valid_o = retv_q;
  assign ret_pc_o    = ret_pc_q;
  assign active_o    = active;
  assign active_ch_o = act_ch_q;
  assign pending_o   = pend_q;
  assign enable_o    = en_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_int_vector_ctrl.sv
// Scoreboard bench for int_vector_ctrl: stimulus pushes expected TAKE/RET pulses, a monitor checks them.
module tb_int_vector_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  int_req = '0;
  logic        step = 1'b0, reti = 1'b0, cfg_we = 1'b0;
  logic [15:0] pc = '0, cfg_data = '0;
  logic [1:0]  cfg_sel = '0;
  logic [2:0]  cfg_ch = '0;
  logic        take, ret_valid, active, err;
  logic [15:0] vector, ret_pc;
  logic [2:0]  active_ch;
  logic [7:0]  pending, enable;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    bit          is_ret;
    logic [15:0] val;
    logic [2:0]  ch;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int_vector_ctrl #(.CHANNELS(8), .PC_W(16), .DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .int_req_i(int_req), .step_i(step), .reti_i(reti),
    .pc_i(pc), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_ch_i(cfg_ch),
    .cfg_data_i(cfg_data), .take_o(take), .vector_o(vector), .ret_valid_o(ret_valid),
    .ret_pc_o(ret_pc), .active_o(active), .active_ch_o(active_ch), .pending_o(pending),
    .enable_o(enable), .err_o(err)
  );

  always #5 clk = ~clk;

  // Monitor: every TAKE/RET_VALID pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (take || ret_valid)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_pulse: take=%0b ret_valid=%0b vector=0x%0h ret_pc=0x%0h, required none",
                 take, ret_valid, vector, ret_pc);
      end else begin
        e = q.pop_front();
        if ((e.is_ret != ret_valid) || (e.is_ret == take) ||
            ((e.is_ret ? ret_pc : vector) !== e.val) || (active_ch !== e.ch)) begin
          n_miss++;
          $display("FAIL pulse: take=%0b ret=%0b addr=0x%0h ch=%0d, required %s addr=0x%0h ch=%0d",
                   take, ret_valid, e.is_ret ? ret_pc : vector, active_ch,
                   e.is_ret ? "ret" : "take", e.val, e.ch);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [2:0] ch, input logic [15:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    int_req = m;
    tick();
    int_req = '0;
  endtask

  task automatic push(input bit r, input logic [15:0] v, input logic [2:0] c);
    q.push_back('{is_ret: r, val: v, ch: c});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_pending", 32'(pending), 0);
    chk("reset_enable", 32'(enable), 0);
    chk("reset_active", 32'({active, active_ch}), 0);
    chk("reset_outs", 32'({take, ret_valid, err}), 0);
    chk("reset_vec_ret", {vector, ret_pc}, 0);

    // Basic entry on ch3
    cfg(2'b00, 3'd3, 16'h1234);
    cfg(2'b01, 3'd3, 16'h0001);
    pulse(8'h08);
    chk("pend_ch3", 32'(pending), 32'h08);
    step = 1'b1; pc = 16'h0040; push(0, 16'h1234, 3'd3);
    tick(); step = 1'b0;
    chk("after_take_pending", 32'(pending), 0);
    chk("after_take_active", 32'(active), 1);

    cfg(2'b00, 3'd1, 16'h2000);
    cfg(2'b01, 3'd1, 16'h0001);
`ifdef INT_NEST_EN
    cfg(2'b00, 3'd5, 16'h5000);
    cfg(2'b01, 3'd5, 16'h0001);
    pulse(8'h22);
    chk("pend_1_5", 32'(pending), 32'h22);
    step = 1'b1; pc = 16'h1240; push(0, 16'h2000, 3'd1);
    tick(); step = 1'b0;
    chk("ch5_still_pending", 32'(pending), 32'h20);
    reti = 1'b1; push(1, 16'h1240, 3'd3);
    tick();
    step = 1'b1; push(1, 16'h0040, 3'd0);       // STEP with RETI: only the return
    tick(); reti = 1'b0;
    pc = 16'h0100; push(0, 16'h5000, 3'd5);
    tick(); step = 1'b0;
    reti = 1'b1; push(1, 16'h0100, 3'd0);
    tick(); reti = 1'b0;

    // Stack full at DEPTH=2
    cfg(2'b00, 3'd7, 16'h7000);
    cfg(2'b00, 3'd6, 16'h6000);
    cfg(2'b01, 3'd7, 16'h0001);
    cfg(2'b01, 3'd6, 16'h0001);
    pulse(8'h80);
    step = 1'b1; pc = 16'h0200; push(0, 16'h7000, 3'd7);
    tick(); step = 1'b0;
    pulse(8'h40);
    step = 1'b1; pc = 16'h0300; push(0, 16'h6000, 3'd6);
    tick(); step = 1'b0;
    pulse(8'h20);
    step = 1'b1; pc = 16'h0400;
    tick(); tick(); step = 1'b0;
    chk("full_pending", 32'(pending), 32'h20);
    chk("full_active_ch", 32'(active_ch), 6);
    reti = 1'b1; push(1, 16'h0300, 3'd7);
    tick(); reti = 1'b0;
    step = 1'b1; pc = 16'h0500; push(0, 16'h5000, 3'd5);
    tick(); step = 1'b0;
    reti = 1'b1; push(1, 16'h0500, 3'd7);
    tick(); push(1, 16'h0200, 3'd0);
    tick(); reti = 1'b0;
`else
    // Without nesting a higher-priority request waits for RETI
    pulse(8'h02);
    step = 1'b1; pc = 16'h1240;
    tick(); tick(); step = 1'b0;
    chk("nonest_pending", 32'(pending), 32'h02);
    chk("nonest_active_ch", 32'(active_ch), 3);
    step = 1'b1; reti = 1'b1; push(1, 16'h0040, 3'd0);
    tick(); reti = 1'b0;
    pc = 16'h0100; push(0, 16'h2000, 3'd1);
    tick(); step = 1'b0;
    reti = 1'b1; push(1, 16'h0100, 3'd0);
    tick(); reti = 1'b0;
`endif
    chk("idle_active", 32'(active), 0);

    // RETI while idle
    reti = 1'b1;
    tick(); reti = 1'b0;
    chk("err_set", 32'(err), 1);
    cfg(2'b11, 3'd0, 16'h0000);
    chk("err_clr", 32'(err), 0);

    // Disabled channel keeps pending; enable applies from the next cycle
    cfg(2'b00, 3'd2, 16'h2222);
    pulse(8'h04);
    step = 1'b1; pc = 16'h0600;
    tick(); tick();
    chk("disabled_pending", 32'(pending), 32'h04);
    cfg_we = 1'b1; cfg_sel = 2'b01; cfg_ch = 3'd2; cfg_data = 16'h0001;
    tick(); cfg_we = 1'b0;
    pc = 16'h0700; push(0, 16'h2222, 3'd2);
    tick(); step = 1'b0;
    reti = 1'b1; push(1, 16'h0700, 3'd0);
    tick(); reti = 1'b0;

    // Edge beats clear-pending on the same channel
    int_req = 8'h04; cfg_we = 1'b1; cfg_sel = 2'b10; cfg_ch = 3'd2;
    tick(); int_req = '0; cfg_we = 1'b0;
    chk("set_wins", 32'(pending), 32'h04);
    // Vector write during take: old vector issued
    cfg_we = 1'b1; cfg_sel = 2'b00; cfg_ch = 3'd2; cfg_data = 16'h3333;
    step = 1'b1; pc = 16'h0800; push(0, 16'h2222, 3'd2);
    tick(); step = 1'b0; cfg_we = 1'b0;
    reti = 1'b1; push(1, 16'h0800, 3'd0);
    tick(); reti = 1'b0;

    // Reset with a TAKE in flight
    pulse(8'h04);
    step = 1'b1; pc = 16'h0900;
    tick(); step = 1'b0;
    chk("inflight_take", 32'({take, vector}), 32'h1_3333);
    rst_n = 1'b0;
    #1;
    chk("rst_take", 32'({take, ret_valid}), 0);
    chk("rst_active", 32'({active, active_ch}), 0);
    chk("rst_pend_en", 32'({pending, enable}), 0);
    tick(); rst_n = 1'b1;
    tick(); tick();
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
